// File: rtl/matrix_inv2x2_if.sv
// ---------------------------------------------------------------------------
// matrix_inv2x2_if
// Handshake and data bundle for the 2x2 fixed-point matrix inverter.
//   start/ready            request handshake (accept when both high)
//   a_in,b_in,c_in,d_in    input matrix [[a,b],[c,d]], signed Q(FRAC_W)
//   out_valid              one-cycle result strobe
//   i00,i01,i10,i11        inverse elements, signed Q(FRAC_W)
//   singular, sat          result flags (det==0, clipping occurred)
// master: the requester side; slave: the inverter.
// ---------------------------------------------------------------------------
interface matrix_inv2x2_if #(
    parameter int DATA_W = 16
);
    logic                     start;
    logic                     ready;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] b_in;
    logic signed [DATA_W-1:0] c_in;
    logic signed [DATA_W-1:0] d_in;
    logic                     out_valid;
    logic signed [DATA_W-1:0] i00;
    logic signed [DATA_W-1:0] i01;
    logic signed [DATA_W-1:0] i10;
    logic signed [DATA_W-1:0] i11;
    logic                     singular;
    logic                     sat;

    modport master (
        output start, a_in, b_in, c_in, d_in,
        input  ready, out_valid, i00, i01, i10, i11, singular, sat
    );

    modport slave (
        input  start, a_in, b_in, c_in, d_in,
        output ready, out_valid, i00, i01, i10, i11, singular, sat
    );
endinterface

// File: rtl/matrix_inv2x2_seq.sv
// ---------------------------------------------------------------------------
// matrix_inv2x2_seq
// Sequential 2x2 signed fixed-point matrix inverter: inv = adj / det.
// A single restoring divider produces one quotient bit per cycle and is
// reused for the four adjugate elements (d, -b, -c, a).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   matrix_inv2x2_if.slave (start/ready, a..d in, out_valid, i00..i11,
//         singular, sat)
// Latency from accept to out_valid: 2 + 4*NUM_W cycles, or 2 when singular.
// ---------------------------------------------------------------------------
module matrix_inv2x2_seq #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    matrix_inv2x2_if.slave bus
);
    localparam int NUM_W = DATA_W + 2 * FRAC_W;
    localparam int DET_W = 2 * DATA_W + 1;
    localparam int CNT_W = $clog2(NUM_W + 1);

    // Quotient limits for the positive and negative output ranges.
    localparam logic [NUM_W-1:0]  POS_LIM  = {{(NUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic [NUM_W-1:0]  NEG_LIM  = {{(NUM_W - DATA_W){1'b0}}, 1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_OUT  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_OUT  = {1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DET  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_r;
    logic signed [DATA_W-1:0] a_r, b_r, c_r, d_r;
    logic [DET_W-1:0]         det_mag_r;
    logic                     det_neg_r;
    logic [1:0]               k_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [NUM_W-1:0]         num_r;
    logic [NUM_W-2:0]         quo_r;     // top quotient bit only ever exists in quo_next_s
    logic [DET_W-1:0]         rem_r;
    logic                     neg_r;
    logic signed [DATA_W-1:0] i00_r, i01_r, i10_r, i11_r;
    logic                     singular_r;
    logic                     sat_r;
    logic                     out_valid_r;
    logic                     ready_r;

    logic signed [DET_W-1:0]  det_s;
    logic [1:0]               k_load_s;
    logic signed [DATA_W:0]   adj_s;
    logic [DATA_W:0]          adj_mag_s;
    logic [NUM_W-1:0]         num_load_s;
    logic                     neg_load_s;
    logic [DET_W:0]           rem_shift_s;
    logic [DET_W-1:0]         rem_next_s;
    logic [NUM_W-1:0]         quo_next_s;
    logic [DATA_W-1:0]        elem_s;
    logic                     elem_sat_s;

    function automatic logic signed [DET_W-1:0] sext_det(input logic [DATA_W-1:0] v);
        return $signed({{(DET_W - DATA_W){v[DATA_W-1]}}, v});
    endfunction

    // Full-width determinant a*d - b*c in Q(2*FRAC_W).
    always_comb begin
        det_s = sext_det(a_r) * sext_det(d_r) - sext_det(b_r) * sext_det(c_r);
    end

    // Select the adjugate element to load next and form numerator and result sign.
    // In DET the first element is loaded; in DIV the one after the current k.
    always_comb begin
        k_load_s = (state_r == DIV) ? (k_r + 2'd1) : 2'd0;
        case (k_load_s)
            2'd0:    adj_s = $signed({d_r[DATA_W-1], d_r});
            2'd1:    adj_s = -$signed({b_r[DATA_W-1], b_r});
            2'd2:    adj_s = -$signed({c_r[DATA_W-1], c_r});
            2'd3:    adj_s = $signed({a_r[DATA_W-1], a_r});
            default: adj_s = '0;
        endcase
        if (adj_s[DATA_W]) begin
            adj_mag_s = -adj_s;
        end else begin
            adj_mag_s = adj_s;
        end
        // |adj| never exceeds 2^(DATA_W-1), so DATA_W bits hold it unsigned.
        num_load_s = {adj_mag_s[DATA_W-1:0], {(2 * FRAC_W){1'b0}}};
        if (state_r == DIV) begin
            neg_load_s = adj_s[DATA_W] ^ det_neg_r;
        end else begin
            neg_load_s = adj_s[DATA_W] ^ det_s[DET_W-1];
        end
    end

    // One restoring-division step; remainder stays below the divisor.
    always_comb begin
        rem_shift_s = {rem_r, num_r[NUM_W-1]};
        if (rem_shift_s >= {1'b0, det_mag_r}) begin
            rem_next_s = rem_shift_s[DET_W-1:0] - det_mag_r;
            quo_next_s = {quo_r, 1'b1};
        end else begin
            rem_next_s = rem_shift_s[DET_W-1:0];
            quo_next_s = {quo_r, 1'b0};
        end
    end

    // Apply sign and clip the finished quotient into the DATA_W signed range.
    always_comb begin
        if (neg_r) begin
            if (quo_next_s > NEG_LIM) begin
                elem_s     = MIN_OUT;
                elem_sat_s = 1'b1;
            end else begin
                elem_s     = -quo_next_s[DATA_W-1:0];
                elem_sat_s = 1'b0;
            end
        end else begin
            if (quo_next_s > POS_LIM) begin
                elem_s     = MAX_OUT;
                elem_sat_s = 1'b1;
            end else begin
                elem_s     = quo_next_s[DATA_W-1:0];
                elem_sat_s = 1'b0;
            end
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            d_r         <= '0;
            det_mag_r   <= '0;
            det_neg_r   <= 1'b0;
            k_r         <= 2'd0;
            cnt_r       <= '0;
            num_r       <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            neg_r       <= 1'b0;
            i00_r       <= '0;
            i01_r       <= '0;
            i10_r       <= '0;
            i11_r       <= '0;
            singular_r  <= 1'b0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (bus.start && ready_r) begin
                        a_r        <= bus.a_in;
                        b_r        <= bus.b_in;
                        c_r        <= bus.c_in;
                        d_r        <= bus.d_in;
                        singular_r <= 1'b0;
                        sat_r      <= 1'b0;
                        ready_r    <= 1'b0;
                        state_r    <= DET;
                    end else begin
                        ready_r    <= 1'b1;
                    end
                end
                DET: begin
                    if (det_s == '0) begin
                        singular_r <= 1'b1;
                        i00_r      <= '0;
                        i01_r      <= '0;
                        i10_r      <= '0;
                        i11_r      <= '0;
                        state_r    <= DONE;
                    end else begin
                        if (det_s[DET_W-1]) begin
                            det_mag_r <= -det_s;
                        end else begin
                            det_mag_r <= det_s;
                        end
                        det_neg_r <= det_s[DET_W-1];
                        k_r       <= 2'd0;
                        cnt_r     <= '0;
                        num_r     <= num_load_s;
                        neg_r     <= neg_load_s;
                        rem_r     <= '0;
                        quo_r     <= '0;
                        state_r   <= DIV;
                    end
                end
                DIV: begin
                    if (cnt_r == LAST_CNT) begin
                        case (k_r)
                            2'd0:    i00_r <= elem_s;
                            2'd1:    i01_r <= elem_s;
                            2'd2:    i10_r <= elem_s;
                            2'd3:    i11_r <= elem_s;
                            default: begin end
                        endcase
                        sat_r <= sat_r | elem_sat_s;
                        if (k_r == 2'd3) begin
                            state_r <= DONE;
                        end else begin
                            k_r   <= k_r + 2'd1;
                            cnt_r <= '0;
                            num_r <= num_load_s;
                            neg_r <= neg_load_s;
                            rem_r <= '0;
                            quo_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        num_r <= {num_r[NUM_W-2:0], 1'b0};
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s[NUM_W-2:0];
                    end
                end
                DONE: begin
                    out_valid_r <= 1'b1;
                    ready_r     <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    ready_r     <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.i00       = i00_r;
    assign bus.i01       = i01_r;
    assign bus.i10       = i10_r;
    assign bus.i11       = i11_r;
    assign bus.singular  = singular_r;
    assign bus.sat       = sat_r;
endmodule
